// File: rtl/sr_pkg.sv
// Shared definitions for the serial deframer: FSM encoding and the default sync
// constants also used by the upstream framer.
package sr_pkg;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } sr_state_e;

  localparam int unsigned SYNC_W_DEF   = 8;
  localparam logic [7:0]  SYNC_PAT_DEF = 8'hA5;

endpackage

// File: rtl/sr_deframer_if.sv
// Parallel word output of the deframer: valid/ready handshake with data.
interface sr_deframer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/sr_sync_match.sv
// Sync hunter: shifts qualified bits into a window and flags a match only once the
// window has been completely refilled since the last clear.
module sr_sync_match
  import sr_pkg::*;
#(
  parameter int unsigned        SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(SYNC_PAT_DEF)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  input  logic clear,
  output logic match
);

  localparam int unsigned FW = $clog2(SYNC_W + 1);

  logic [SYNC_W-1:0] window_q, window_d;
  logic [FW-1:0]     fill_q, fill_d;

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    if (clear) begin
      fill_d = '0;
    end else if (en) begin
      window_d = {window_q[SYNC_W-2:0], din};
      if (fill_q != FW'(SYNC_W)) fill_d = fill_q + 1'b1;
    end
    // Evaluated on the post-shift view so the completing bit itself can match.
    match = en && !clear && (fill_d == FW'(SYNC_W)) && (window_d == SYNC_PAT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window_q <= '0;
      fill_q   <= '0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

endmodule

// File: rtl/sr_deframer.sv
// Serial deframer: hunts for sync, then assembles FRAME_WORDS words per frame and
// presents them through a one-entry valid/ready holding register.
module sr_deframer
  import sr_pkg::*;
#(
  parameter int unsigned        WIDTH       = 8,
  parameter int unsigned        SYNC_W      = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT    = SYNC_W'(SYNC_PAT_DEF),
  parameter int unsigned        FRAME_WORDS = 4,
  parameter int unsigned        LSB_FIRST   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sin,
  input  logic                 sin_en,
  input  logic                 hunt_req,
  input  logic                 ovf_clr,
  output logic                 locked,
  output logic                 ovf,
  sr_deframer_if.master        out_if
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  sr_state_e        state_q, state_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [WW-1:0]    wordcnt_q, wordcnt_d;
  logic [WIDTH-1:0] word_q, word_d, word_shift;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             shift_en, word_done, frame_end, drop, match;

  sr_sync_match #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .en    ((state_q == ST_HUNT) && sin_en),
    .din   (sin),
    .clear (hunt_req || frame_end),
    .match (match)
  );

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    wordcnt_d = wordcnt_q;
    word_d    = word_q;
    data_d    = data_q;
    valid_d   = valid_q;
    drop      = 1'b0;

    if (LSB_FIRST != 0) word_shift = {sin, word_q[WIDTH-1:1]};
    else                word_shift = {word_q[WIDTH-2:0], sin};

    shift_en  = (state_q == ST_COLLECT) && sin_en && !hunt_req;
    word_done = shift_en && (bitcnt_q == BW'(WIDTH - 1));
    frame_end = word_done && (wordcnt_q == WW'(FRAME_WORDS - 1));

    if (hunt_req) begin
      state_d   = ST_HUNT;
      bitcnt_d  = '0;
      wordcnt_d = '0;
    end else begin
      unique case (state_q)
        ST_HUNT: begin
          if (match) begin
            state_d   = ST_COLLECT;
            bitcnt_d  = '0;
            wordcnt_d = '0;
          end
        end
        ST_COLLECT: begin
          if (shift_en) begin
            word_d = word_shift;
            if (word_done) begin
              bitcnt_d  = '0;
              wordcnt_d = frame_end ? '0 : wordcnt_q + 1'b1;
              if (frame_end) state_d = ST_HUNT;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // A completing word may refill the holding register in the cycle it drains.
    if (word_done) begin
      if (!valid_q || out_if.out_ready) begin
        data_d  = word_shift;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end

    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_HUNT;
      bitcnt_q  <= '0;
      wordcnt_q <= '0;
      word_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      wordcnt_q <= wordcnt_d;
      word_q    <= word_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign locked           = (state_q == ST_COLLECT);
  assign ovf              = ovf_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;

endmodule

// File: tb/tb_sr_deframer.sv
// Directed bench for sr_deframer with WIDTH=8, SYNC_PAT=A5, FRAME_WORDS=2, MSB first.
module tb_sr_deframer;

  logic clk = 1'b0;
  logic reset, sin, sin_en, hunt_req, ovf_clr;
  logic locked, ovf;
  int   checks = 0;
  int   errors = 0;

  sr_deframer_if #(.WIDTH(8)) bus ();

  sr_deframer #(
    .WIDTH       (8),
    .SYNC_W      (8),
    .SYNC_PAT    (8'hA5),
    .FRAME_WORDS (2),
    .LSB_FIRST   (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sin      (sin),
    .sin_en   (sin_en),
    .hunt_req (hunt_req),
    .ovf_clr  (ovf_clr),
    .locked   (locked),
    .ovf      (ovf),
    .out_if   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Optional idle cycles with garbage on sin precede each qualified bit.
  task automatic send_bit(input logic b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int g = 0; g < gap; g++) begin
      sin    = 1'($urandom);
      sin_en = 1'b0;
      tick();
    end
    sin    = b;
    sin_en = 1'b1;
    tick();
    sin_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int max_gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], max_gap);
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    sin           = 1'b0;
    sin_en        = 1'b0;
    hunt_req      = 1'b0;
    ovf_clr       = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({locked, ovf, bus.out_valid, bus.out_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%b/%b/%h want all 0",
               locked, ovf, bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_lock();
    do_reset();
    bus.out_ready = 1'b1;
    send_byte(8'hA5, 0);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked got %b want 1", locked); end
    send_byte(8'h3C, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      errors++;
      $display("FAIL lock_word0 got v=%b d=%h want v=1 d=3c", bus.out_valid, bus.out_data);
    end
    send_byte(8'hC3, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC3 || locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_word1 got v=%b d=%h l=%b want v=1 d=c3 l=0",
               bus.out_valid, bus.out_data, locked);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL lock_drain got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_partial();
    logic [14:0] s;
    s = 15'b0100101_10100101;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      send_bit(s[i], 0);
      checks++;
      if (locked !== (i == 0)) begin
        errors++;
        $display("FAIL partial_bit%0d got %b want %b", 14 - i, locked, (i == 0));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL bp_word0 got v=%b d=%h o=%b want v=1 d=11 o=0",
               bus.out_valid, bus.out_data, ovf);
    end
    send_byte(8'h22, 0);
    checks++;
    if (bus.out_data !== 8'h11 || bus.out_valid !== 1'b1 || ovf !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL bp_drop got v=%b d=%h o=%b l=%b want v=1 d=11 o=1 l=0",
               bus.out_valid, bus.out_data, ovf, locked);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_ovf_clr got o=%b v=%b want o=0 v=1", ovf, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_accept got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] w;
    w = 8'h22;
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    for (int i = 7; i >= 1; i--) send_bit(w[i], 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin
      errors++;
      $display("FAIL sim_hold got v=%b d=%h want v=1 d=11", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    send_bit(w[0], 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sim_b2b got v=%b d=%h o=%b want v=1 d=22 o=0",
               bus.out_valid, bus.out_data, ovf);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL sim_drain got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_hunt();
    logic [7:0] p;
    p = 8'hA5;
    do_reset();
    bus.out_ready = 1'b1;
    send_byte(8'hA5, 0);
    send_byte(8'hB0, 0);
    hunt_req = 1'b0;
    // Replace the 6th-8th bits: only 5 data bits go in before the hunt request.
    do_reset();
    bus.out_ready = 1'b1;
    send_byte(8'hA5, 0);
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 0);
    hunt_req = 1'b1;
    tick();
    hunt_req = 1'b0;
    checks++;
    if (locked !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL hunt_unlock got l=%b v=%b want 0 0", locked, bus.out_valid);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (locked !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL hunt_nodata got l=%b v=%b want 0 0", locked, bus.out_valid);
    end
    for (int i = 7; i >= 1; i--) send_bit(p[i], 0);
    hunt_req = 1'b1;
    tick();
    hunt_req = 1'b0;
    send_bit(p[0], 0);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL hunt_refill got %b want 0", locked);
    end
    send_byte(8'hA5, 0);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL hunt_relock got %b want 1", locked); end
    send_byte(8'h3C, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      errors++;
      $display("FAIL hunt_word got v=%b d=%h want v=1 d=3c", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    bus.out_ready = 1'b1;
    send_byte(8'hA5, 3);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL gap_lock got %b want 1", locked); end
    send_byte(8'h3C, 3);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      errors++;
      $display("FAIL gap_word0 got v=%b d=%h want v=1 d=3c", bus.out_valid, bus.out_data);
    end
    send_byte(8'hC3, 3);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC3 || locked !== 1'b0) begin
      errors++;
      $display("FAIL gap_word1 got v=%b d=%h l=%b want v=1 d=c3 l=0",
               bus.out_valid, bus.out_data, locked);
    end
    send_byte(8'hA5, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 2);
    reset = 1'b0;
    #1;
    checks++;
    if ({locked, ovf, bus.out_valid, bus.out_data} !== 11'd0) begin
      errors++;
      $display("FAIL gap_midreset got %b/%b/%b/%h want all 0",
               locked, ovf, bus.out_valid, bus.out_data);
    end
    tick();
    reset = 1'b1;
    send_byte(8'hFF, 0);
    checks++;
    if (locked !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL gap_postreset got l=%b v=%b want 0 0", locked, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_partial();
    test_backpressure();
    test_simultaneous();
    test_hunt();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
